// File: rtl/shr_pkg.sv
// Shared types and default sizes for the sequential right shifter.
// State encodings are fixed here so the controller and the shifter use the same values.
package shr_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shr_step.sv
// One-position combinational right shift: fill enters at the MSB, bit 0 leaves as out_bit.
// This is the mirror image of the one-position left-shift cell.
module shr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] f,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    assign shifted = {fill, f[WIDTH-1:1]};
    assign out_bit = f[0];

endmodule

// File: rtl/shr_seq.sv
// Multi-cycle right shifter: load an operand, shift right once per clock for amt cycles,
// then pulse done. The MSB fill comes from cin, or from the current MSB when arith is latched.
module shr_seq
    import shr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    input  logic             cin,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [AMT_W-1:0] cnt;
    logic             arith_lat;
    logic             fill;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;

    assign fill = arith_lat ? f[WIDTH-1] : cin;

    shr_step #(.WIDTH(WIDTH)) u_step (
        .f       (f),
        .fill    (fill),
        .shifted (shifted),
        .out_bit (shift_out)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (amt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == AMT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; cnt never wraps because SHIFT is only entered with a nonzero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            f         <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            arith_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f         <= x;
                        cout      <= 1'b0;
                        cnt       <= amt;
                        arith_lat <= arith;
                    end
                end
                SHIFT: begin
                    f    <= shifted;
                    cout <= shift_out;
                    cnt  <= cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shr_seq.sv
// Scoreboard bench for shr_seq: stimulus pushes hand-computed results, a monitor
// pops and compares them (value, cout, done timing, busy length) on every done pulse.
module tb_shr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [2:0] amt;
    logic       arith;
    logic       cin;
    logic [7:0] f;
    logic       cout;
    logic       busy;
    logic       done;

    shr_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .amt   (amt),
        .arith (arith),
        .cin   (cin),
        .f     (f),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] f;
        logic       cout;
        int         done_cyc;
        int         busy_cycles;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   busy_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_f"},        32'(f),        32'(mon_e.f));
                check({mon_e.name, "_cout"},     32'(cout),     32'(mon_e.cout));
                check({mon_e.name, "_done_cyc"}, 32'(cyc),      32'(mon_e.done_cyc));
                check({mon_e.name, "_busy_len"}, 32'(busy_cnt), 32'(mon_e.busy_cycles));
                check({mon_e.name, "_busy_off"}, 32'(busy),     32'd0);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    // One operation: accept edge, amt shift edges (cin from pat[i]), then the DONE->IDLE edge.
    // With noise set, start is pulsed with other operands during SHIFT and DONE and left high.
    task automatic run_op(input string name, input logic [7:0] xv, input logic [2:0] av,
                          input logic ar, input logic [6:0] pat, input logic noise,
                          input logic [7:0] ef, input logic ec);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        x     = xv;
        amt   = av;
        arith = ar;
        cin   = 1'b0;
        e.f           = ef;
        e.cout        = ec;
        e.done_cyc    = cyc + 1 + int'(av);
        e.busy_cycles = int'(av);
        e.name        = name;
        sb.push_back(e);
        @(posedge clk);
        for (int i = 0; i < int'(av); i++) begin
            @(negedge clk);
            start = noise;
            if (noise) x = ~xv;
            cin = pat[i];
            @(posedge clk);
        end
        @(negedge clk);
        start = noise;
        if (noise) x = 8'h77;
        cin = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = 8'h00;
        amt   = 3'd0;
        arith = 1'b0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_f",    32'(f),    32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Reset two shifts into an amt=5 operation; no done may follow.
        @(negedge clk);
        start = 1'b1;
        x     = 8'hF0;
        amt   = 3'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_f",    32'(f),    32'h3C);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_f",    32'(f),    32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);

        run_op("logical",    8'h81, 3'd1, 1'b0, 7'h00,       1'b0, 8'h40, 1'b1);
        run_op("arith",      8'h96, 3'd3, 1'b1, 7'h00,       1'b0, 8'hF2, 1'b1);
        run_op("amt0",       8'h5A, 3'd0, 1'b0, 7'h00,       1'b0, 8'h5A, 1'b0);
        run_op("fill_ones",  8'h00, 3'd7, 1'b0, 7'h7F,       1'b0, 8'hFE, 1'b0);
        run_op("fill_alt",   8'h00, 3'd7, 1'b0, 7'b1010101,  1'b0, 8'hAA, 1'b0);
        run_op("msb_to_lsb", 8'hA5, 3'd7, 1'b0, 7'h00,       1'b0, 8'h01, 1'b0);
        run_op("sign7",      8'h80, 3'd7, 1'b1, 7'h00,       1'b0, 8'hFF, 1'b0);
        run_op("ignored",    8'h3C, 3'd4, 1'b0, 7'h00,       1'b1, 8'h03, 1'b1);
        run_op("held_start", 8'hC3, 3'd2, 1'b1, 7'h00,       1'b0, 8'hF0, 1'b1);
        for (int a = 1; a <= 7; a++) begin
            run_op($sformatf("walk%0d", a), 8'h80, 3'(a), 1'b0, 7'h00, 1'b0,
                   8'h80 >> a, 1'b0);
        end

        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
